// File: rtl/cdb_pkg.sv
// Shared CDB types: broadcast packet layout and source indices.
// Used by cdb_wb_scheduler and wb_queue.
package cdb_pkg;

    localparam int XLEN        = 32;
    localparam int PRF_LEN     = 6;
    localparam int ROB_LEN     = 5;
    localparam int CDB_NUM_SRC = 4;

    typedef enum logic [1:0] {
        SRC_ALU,
        SRC_MUL,
        SRC_MEM,
        SRC_BR
    } cdb_src_e;

    typedef struct packed {
        logic [XLEN-1:0]    value;
        logic [PRF_LEN-1:0] dest_preg;
        logic [ROB_LEN-1:0] rob_idx;
        logic [XLEN-1:0]    pc;
        logic               has_dest;
        logic               br_direction;
        logic [XLEN-1:0]    br_target_pc;
        logic               br_mis_pred;
        logic               local_pred;
        logic               global_pred;
    } cdb_pkt_t;

endpackage

// File: rtl/wb_queue.sv
// Per-FU writeback FIFO of CDB packets.
// Flush empties the queue in one edge.
module wb_queue
    import cdb_pkg::*;
#(
    parameter int Q_DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  cdb_pkt_t push_pkt,
    input  logic     pop,
    input  logic     flush,
    output logic     full,
    output logic     empty,
    output cdb_pkt_t head
);

    localparam int AW = $clog2(Q_DEPTH);
    localparam logic [AW:0] DEPTH_C = Q_DEPTH[AW:0];

    cdb_pkt_t       r_mem [Q_DEPTH];
    logic [AW-1:0]  r_wr;
    logic [AW-1:0]  r_rd;
    logic [AW:0]    r_cnt;

    assign full  = (r_cnt == DEPTH_C);
    assign empty = (r_cnt == '0);
    assign head  = r_mem[r_rd];

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (push) r_wr <= r_wr + 1'b1;
            if (pop)  r_rd <= r_rd + 1'b1;
            case ({push, pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr] <= push_pkt;
    end

endmodule

// File: rtl/cdb_wb_scheduler.sv
// Round-robin writeback scheduler driving the registered CDB.
// Optional perf counters are built when CDB_PERF_CNT_EN is defined.
module cdb_wb_scheduler
    import cdb_pkg::*;
#(
    parameter int NUM_SRC = CDB_NUM_SRC,
    parameter int Q_DEPTH = 2,
    parameter int CNT_W   = 32
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] src_valid,
    input  cdb_pkt_t           src_pkt [NUM_SRC],
    output logic [NUM_SRC-1:0] src_ready,
    input  logic               flush,
    output logic               cdb_valid,
    output cdb_pkt_t           cdb_pkt,
    output logic [NUM_SRC-1:0] cdb_src_sel,
    output logic [CNT_W-1:0]   perf_grant_cnt [NUM_SRC],
    output logic [CNT_W-1:0]   perf_conflict_cnt
);

    localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0] w_full;
    logic [NUM_SRC-1:0] w_empty;
    logic [NUM_SRC-1:0] w_push;
    logic [NUM_SRC-1:0] w_gnt_oh;
    cdb_pkt_t           w_head [NUM_SRC];
    logic [SEL_W-1:0]   w_gnt_idx;
    logic [SEL_W-1:0]   w_idx;
    logic               w_gnt_any;

    logic [SEL_W-1:0]   r_rr_ptr;
    logic               r_cdb_valid;
    cdb_pkt_t           r_cdb_pkt;
    logic [NUM_SRC-1:0] r_cdb_sel;

    // Readiness looks only at registered occupancy, never at this cycle's pop.
    assign src_ready = reset_n ? ~w_full : '0;
    assign w_push    = src_valid & src_ready & {NUM_SRC{~flush}};

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_q
        wb_queue #(
            .Q_DEPTH (Q_DEPTH)
        ) u_q (
            .clk      (clock),
            .rst_n    (reset_n),
            .push     (w_push[g]),
            .push_pkt (src_pkt[g]),
            .pop      (w_gnt_oh[g]),
            .flush    (flush),
            .full     (w_full[g]),
            .empty    (w_empty[g]),
            .head     (w_head[g])
        );
    end

    // Scan downward so the last hit is the closest one at or above rr_ptr.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        w_idx     = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            w_idx = SEL_W'((int'(r_rr_ptr) + k) % NUM_SRC);
            if (!w_empty[w_idx]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = w_idx;
            end
        end
        if (flush) w_gnt_any = 1'b0;
    end

    always_comb begin
        w_gnt_oh = '0;
        if (w_gnt_any) w_gnt_oh[w_gnt_idx] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_rr_ptr    <= '0;
            r_cdb_valid <= 1'b0;
            r_cdb_pkt   <= '0;
            r_cdb_sel   <= '0;
        end else begin
            r_cdb_valid <= w_gnt_any;
            r_cdb_sel   <= w_gnt_oh;
            if (w_gnt_any) begin
                r_cdb_pkt <= w_head[w_gnt_idx];
                r_rr_ptr  <= SEL_W'((int'(w_gnt_idx) + 1) % NUM_SRC);
            end
        end
    end

    assign cdb_valid   = r_cdb_valid;
    assign cdb_pkt     = r_cdb_pkt;
    assign cdb_src_sel = r_cdb_sel;

`ifdef CDB_PERF_CNT_EN
    logic [CNT_W-1:0] r_gnt_cnt [NUM_SRC];
    logic [CNT_W-1:0] r_conf_cnt;
    logic             w_conflict;

    assign w_conflict = !flush && ($countones(~w_empty) >= 2);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_SRC; i++) r_gnt_cnt[i] <= '0;
            r_conf_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (w_gnt_oh[i] && (r_gnt_cnt[i] != '1))
                    r_gnt_cnt[i] <= r_gnt_cnt[i] + 1'b1;
            end
            if (w_conflict && (r_conf_cnt != '1))
                r_conf_cnt <= r_conf_cnt + 1'b1;
        end
    end

    assign perf_grant_cnt    = r_gnt_cnt;
    assign perf_conflict_cnt = r_conf_cnt;
`else
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) perf_grant_cnt[i] = '0;
        perf_conflict_cnt = '0;
    end
`endif

endmodule
